dcache_mem_responder: RTL

- Memory-side responder for the load/store buffer's data-access interface.
- Accepts one-cycle access requests (byte, half word or word; read or write) and performs each as a little-endian, byte-serial access on the 8-bit RAM/IO bus.
- Returns completion to the requester: a one-cycle `dataValid` pulse for reads, a one-cycle `dataWriteSuc` pulse for writes.
- Sits between the LSB and the external memory arbiter; serves one request at a time.

---
 rtl/dcache_mem_responder_pkg.sv | 34 +++
 rtl/dcache_mem_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dcache_mem_responder_pkg.sv
// Shared types and helpers for the data-cache memory responder.
package dcache_mem_responder_pkg;

    localparam int unsigned ADDR_WIDTH_DEFAULT = 32;
    localparam int unsigned IO_SEL_HI_DEFAULT  = 17;
    localparam int unsigned CNT_WIDTH          = 3;
    localparam logic [1:0]  IO_REGION_SEL      = 2'b11;

    typedef enum logic [1:0] {
        ACC_NONE = 2'b00,
        ACC_BYTE = 2'b01,
        ACC_HALF = 2'b10,
        ACC_WORD = 2'b11
    } accessKind_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WRITE  = 3'd2,
        DONE_R = 3'd3,
        DONE_W = 3'd4
    } respState_e;

    // Number of bus bytes moved for a request size.
    function automatic logic [CNT_WIDTH-1:0] sizeToBytes(input logic [1:0] kind);
        case (kind)
            ACC_BYTE: sizeToBytes = 3'd1;
            ACC_HALF: sizeToBytes = 3'd2;
            ACC_WORD: sizeToBytes = 3'd4;
            default:  sizeToBytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dcache_mem_responder.sv
// Byte-serial little-endian responder between the LSB and the 8-bit RAM/IO bus.
// Optional IO write backpressure is enabled with `define IO_BACKPRESSURE_EN.
module dcache_mem_responder
    import dcache_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int unsigned IO_SEL_HI  = IO_SEL_HI_DEFAULT
) (
    input  logic                  clockIn,
    input  logic                  resetNIn,
    input  logic                  readyIn,
    input  logic                  clearIn,
    input  logic [1:0]            accessType,
    input  logic                  readWriteIn,
    input  logic [ADDR_WIDTH-1:0] dataAddr,
    input  logic [31:0]           dataOut,
    output logic                  dataValid,
    output logic [31:0]           dataIn,
    output logic                  dataWriteSuc,
    input  logic [7:0]            memDataIn,
    output logic [7:0]            memDataOut,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memWrite,
    input  logic                  ioBufferFull
);

    respState_e            state, stateNext;
    logic [CNT_WIDTH-1:0]  cntQ, cntNext;
    logic [CNT_WIDTH-1:0]  capQ, capNext;
    logic [CNT_WIDTH-1:0]  nBytesQ, nBytesNext;
    logic                  issuedQ, issuedNext;
    logic [31:0]           bufQ, bufNext;
    logic [31:0]           wdataQ, wdataNext;
    logic [ADDR_WIDTH-1:0] memAddrQ, memAddrNext;
    logic                  memWriteQ, memWriteNext;
    logic [7:0]            memDataOutQ, memDataOutNext;
    logic [31:0]           dataInQ, dataInNext;
    logic                  dataValidQ, dataValidNext;
    logic                  writeSucQ, writeSucNext;
    logic                  inIoRegion;
    logic                  ioStall;

    assign inIoRegion = (memAddrQ[IO_SEL_HI -: 2] == IO_REGION_SEL);

`ifdef IO_BACKPRESSURE_EN
    assign ioStall = (state == WRITE) && inIoRegion && ioBufferFull;
`else
    logic unusedIo;
    assign unusedIo = inIoRegion & ioBufferFull;
    assign ioStall  = 1'b0;
`endif

    // Bus is parked whenever the pipeline is frozen so no IO byte is seen twice.
    assign memAddr      = readyIn ? memAddrQ : '0;
    assign memWrite     = readyIn & memWriteQ & ~ioStall;
    assign memDataOut   = memDataOutQ;
    assign dataIn       = dataInQ;
    assign dataValid    = dataValidQ;
    assign dataWriteSuc = writeSucQ;

    always_ff @(posedge clockIn or negedge resetNIn) begin
        if (!resetNIn) begin
            state       <= IDLE;
            cntQ        <= '0;
            capQ        <= '0;
            nBytesQ     <= '0;
            issuedQ     <= 1'b0;
            bufQ        <= '0;
            wdataQ      <= '0;
            memAddrQ    <= '0;
            memWriteQ   <= 1'b0;
            memDataOutQ <= '0;
            dataInQ     <= '0;
            dataValidQ  <= 1'b0;
            writeSucQ   <= 1'b0;
        end else begin
            state       <= stateNext;
            cntQ        <= cntNext;
            capQ        <= capNext;
            nBytesQ     <= nBytesNext;
            issuedQ     <= issuedNext;
            bufQ        <= bufNext;
            wdataQ      <= wdataNext;
            memAddrQ    <= memAddrNext;
            memWriteQ   <= memWriteNext;
            memDataOutQ <= memDataOutNext;
            dataInQ     <= dataInNext;
            dataValidQ  <= dataValidNext;
            writeSucQ   <= writeSucNext;
        end
    end

    always_comb begin
        stateNext      = state;
        cntNext        = cntQ;
        capNext        = capQ;
        nBytesNext     = nBytesQ;
        issuedNext     = 1'b0;
        bufNext        = bufQ;
        wdataNext      = wdataQ;
        memAddrNext    = memAddrQ;
        memWriteNext   = memWriteQ;
        memDataOutNext = memDataOutQ;
        dataInNext     = dataInQ;
        dataValidNext  = dataValidQ;
        writeSucNext   = writeSucQ;

        // A byte issued in the last ready cycle lands now, even during a stall.
        if (issuedQ) begin
            bufNext[{capQ[1:0], 3'b000} +: 8] = memDataIn;
            capNext = capQ + 3'd1;
        end

        if (readyIn) begin
            dataValidNext = 1'b0;
            writeSucNext  = 1'b0;
            unique case (state)
                IDLE, DONE_R, DONE_W: begin
                    stateNext      = IDLE;
                    memAddrNext    = '0;
                    memWriteNext   = 1'b0;
                    memDataOutNext = '0;
                    if (!clearIn && accessType != ACC_NONE) begin
                        nBytesNext  = sizeToBytes(accessType);
                        cntNext     = '0;
                        capNext     = '0;
                        bufNext     = '0;
                        wdataNext   = dataOut;
                        memAddrNext = dataAddr;
                        if (readWriteIn) begin
                            stateNext = READ;
                        end else begin
                            stateNext      = WRITE;
                            memWriteNext   = 1'b1;
                            memDataOutNext = dataOut[7:0];
                        end
                    end
                end
                READ: begin
                    if (clearIn) begin
                        stateNext   = IDLE;
                        memAddrNext = '0;
                    end else if (capNext == nBytesQ) begin
                        stateNext     = DONE_R;
                        dataInNext    = bufNext;
                        dataValidNext = 1'b1;
                    end else if (cntQ < nBytesQ) begin
                        issuedNext  = 1'b1;
                        cntNext     = cntQ + 3'd1;
                        memAddrNext = ((cntQ + 3'd1) < nBytesQ) ? memAddrQ + ADDR_WIDTH'(1) : '0;
                    end
                end
                WRITE: begin
                    if (!ioStall) begin
                        if ((cntQ + 3'd1) == nBytesQ) begin
                            stateNext      = DONE_W;
                            writeSucNext   = 1'b1;
                            memAddrNext    = '0;
                            memWriteNext   = 1'b0;
                            memDataOutNext = '0;
                        end else begin
                            cntNext        = cntQ + 3'd1;
                            memAddrNext    = memAddrQ + ADDR_WIDTH'(1);
                            memDataOutNext = wdataQ[{cntQ[1:0] + 2'd1, 3'b000} +: 8];
                        end
                    end
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

endmodule
